// File: rtl/mmu_translator.sv
// Page-translating MMU: 24-bit 68000 logical page to 28-bit physical page.
// User pages come from an external page-table RAM; supervisor pages use a fixed map plus two windows.
module mmu_translator (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [23:12]  addr_in,
  input  logic [2:0]    fc,
  input  logic [3:0]    user_map,
  input  logic [15:0]   supervisor_map_1,
  input  logic [15:0]   supervisor_map_2,
  output logic [15:0]   table_ram_addr_bus,
  input  logic [15:0]   table_ram_data_bus,
  output logic [27:12]  addr_out
);

  logic        en_q;
  logic        sup_q;
  logic [15:0] page_q;
  logic [15:0] page_d;

  // Only fc[2] selects the mode; the window bases are 8 bits wide.
  logic unused_bits;
  assign unused_bits = ^{fc[1:0], supervisor_map_1[15:8], supervisor_map_2[15:8]};

  always_comb begin
    page_d = 16'h0000;
    casez (addr_in[23:20])
      4'b00??: page_d = {6'b100000, addr_in[21:12]};
      4'b01??: page_d = {6'b010000, addr_in[21:12]};
      4'b1000: page_d = {8'h03, addr_in[19:12]};
      4'b1001: page_d = addr_in[19] ? {9'h004, addr_in[18:12]}
                                    : {9'h002, addr_in[18:12]};
      4'b1010: page_d = {supervisor_map_1[7:0], addr_in[19:12]};
      4'b1011: page_d = {supervisor_map_2[7:0], addr_in[19:12]};
      default: page_d = {4'h3, addr_in[23:12]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      sup_q  <= 1'b0;
      page_q <= 16'h0000;
    end else begin
      en_q   <= enable;
      sup_q  <= fc[2];
      page_q <= page_d;
    end
  end

  // Lookup address is combinational so the synchronous RAM samples it at the next edge.
  assign table_ram_addr_bus = (enable && !fc[2]) ? {user_map, addr_in} : 16'bz;
  assign addr_out           = en_q ? (sup_q ? page_q : table_ram_data_bus) : 16'bz;

endmodule

// File: tb/tb_mmu_translator.sv
// Directed bench for mmu_translator; tri-state outputs float high through pull-ups when released.
module tb_mmu_translator;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [11:0] addr_in;
  logic [2:0]  fc;
  logic [3:0]  user_map;
  logic [15:0] supervisor_map_1;
  logic [15:0] supervisor_map_2;
  logic [15:0] table_ram_data_bus;
  tri1  [15:0] table_ram_addr_bus;
  tri1  [15:0] addr_out;

  localparam logic [15:0] HIZ = 16'hFFFF;

  int checks   = 0;
  int failures = 0;

  mmu_translator dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .enable             (enable),
    .addr_in            (addr_in),
    .fc                 (fc),
    .user_map           (user_map),
    .supervisor_map_1   (supervisor_map_1),
    .supervisor_map_2   (supervisor_map_2),
    .table_ram_addr_bus (table_ram_addr_bus),
    .table_ram_data_bus (table_ram_data_bus),
    .addr_out           (addr_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic sup_req(input logic [11:0] a, input logic [15:0] exp);
    @(negedge clk);
    fc      = 3'b101;
    enable  = 1'b1;
    addr_in = a;
    @(posedge clk);
    #1;
    check_eq($sformatf("sup %h m1=%h m2=%h", a, supervisor_map_1[7:0], supervisor_map_2[7:0]),
             addr_out, exp);
  endtask

  task automatic user_lookup(input logic [3:0] m, input logic [11:0] a, input logic [15:0] exp);
    @(negedge clk);
    fc       = 3'b001;
    enable   = 1'b1;
    user_map = m;
    addr_in  = a;
    #1;
    check_eq($sformatf("lookup map=%0d page=%h", m, a), table_ram_addr_bus, exp);
  endtask

  initial begin
    rst_n              = 1'b0;
    enable             = 1'b0;
    addr_in            = 12'h000;
    fc                 = 3'b001;
    user_map           = 4'h0;
    supervisor_map_1   = 16'h0000;
    supervisor_map_2   = 16'h0000;
    table_ram_data_bus = 16'h0000;
    #1;
    check_eq("reset addr_out", addr_out, HIZ);
    check_eq("reset ram_addr idle", table_ram_addr_bus, HIZ);
    #12;
    rst_n = 1'b1;

    // User data path: RAM data passes straight through one clock after enable.
    @(negedge clk);
    fc = 3'b001; addr_in = 12'h000; table_ram_data_bus = 16'h0002; enable = 1'b1;
    @(posedge clk);
    #1;
    check_eq("user data", addr_out, 16'h0002);
    table_ram_data_bus = 16'h1234;
    #1;
    check_eq("user data comb", addr_out, 16'h1234);
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    check_eq("user disable", addr_out, HIZ);

    user_lookup(4'd0, 12'h000, 16'h0000);
    user_lookup(4'd1, 12'h000, 16'h1000);
    user_lookup(4'd0, 12'h002, 16'h0002);
    user_lookup(4'd1, 12'h002, 16'h1002);
    user_lookup(4'd4, 12'h002, 16'h4002);
    user_lookup(4'd15, 12'hABC, 16'hFABC);
    @(negedge clk);
    fc = 3'b101;
    #1;
    check_eq("lookup sup hiz", table_ram_addr_bus, HIZ);
    fc = 3'b000;
    enable = 1'b0;
    #1;
    check_eq("lookup disabled hiz", table_ram_addr_bus, HIZ);

    // Supervisor fixed map, issued back to back.
    sup_req(12'h000, 16'h8000);
    sup_req(12'h3FF, 16'h83FF);
    sup_req(12'h400, 16'h4000);
    sup_req(12'h7FE, 16'h43FE);
    sup_req(12'hC00, 16'h3C00);
    sup_req(12'hF0E, 16'h3F0E);
    sup_req(12'hFFF, 16'h3FFF);
    sup_req(12'h800, 16'h0300);
    sup_req(12'h8FF, 16'h03FF);
    sup_req(12'h900, 16'h0100);
    sup_req(12'h97F, 16'h017F);
    sup_req(12'h980, 16'h0200);
    sup_req(12'h9FF, 16'h027F);

    supervisor_map_1 = 16'hAA01;
    supervisor_map_2 = 16'h5502;
    sup_req(12'hA00, 16'h0100);
    sup_req(12'hAFF, 16'h01FF);
    sup_req(12'hB00, 16'h0200);
    sup_req(12'hBFF, 16'h02FF);
    supervisor_map_1 = 16'h00FF;
    supervisor_map_2 = 16'h00FE;
    sup_req(12'hA00, 16'hFF00);
    sup_req(12'hB00, 16'hFE00);
    supervisor_map_1 = 16'h007F;
    supervisor_map_2 = 16'h007F;
    sup_req(12'hA00, 16'h7F00);
    sup_req(12'hB00, 16'h7F00);

    // Mode switch back to back: next result comes from the RAM data bus.
    @(negedge clk);
    fc = 3'b001; addr_in = 12'h123; user_map = 4'd2; table_ram_data_bus = 16'h0ABC;
    @(posedge clk);
    #1;
    check_eq("mode switch user", addr_out, 16'h0ABC);

    // Asynchronous reset mid-access.
    sup_req(12'h005, 16'h8005);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async reset hiz", addr_out, HIZ);
    fc = 3'b001; user_map = 4'd3; addr_in = 12'h045;
    #1;
    check_eq("reset ram_addr comb", table_ram_addr_bus, 16'h3045);
    @(negedge clk);
    rst_n = 1'b1;
    fc = 3'b101; addr_in = 12'h010; enable = 1'b1;
    #1;
    check_eq("post reset pre edge", addr_out, HIZ);
    @(posedge clk);
    #1;
    check_eq("post reset first", addr_out, 16'h8010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
